// File: rtl/wifi_preamble_pkg.sv
// Shared constants, state type and Q1.15 sample tables for the 802.11a/g legacy preamble.
// The same tables serve as the correlation reference for the receive-side LTS search.
package wifi_preamble_pkg;

    localparam int STS_LEN   = 16;
    localparam int LTS_LEN   = 64;
    localparam int GI2_LEN   = 32;
    localparam int FRAME_LEN = 10 * STS_LEN + GI2_LEN + 2 * LTS_LEN;  // 320 at default reps

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_STS,
        TX_GI,
        TX_LTS1,
        TX_LTS2,
        TX_GAP
    } tx_state_t;

    // Packs one complex sample as {I[31:16], Q[15:0]}, two's complement Q1.15.
    function automatic logic [31:0] iq(input int i, input int q);
        return {i[15:0], q[15:0]};
    endfunction

    // Last beat index (counter terminal count) of each state.
    function automatic logic [15:0] state_last(input tx_state_t s, input int reps, input int gap);
        case (s)
            TX_STS:           return 16'(reps * STS_LEN - 1);
            TX_GI:            return 16'(GI2_LEN - 1);
            TX_LTS1, TX_LTS2: return 16'(LTS_LEN - 1);
            TX_GAP:           return (gap > 0) ? 16'(gap - 1) : 16'd0;
            default:          return 16'd0;
        endcase
    endfunction

    // One 16-sample period of the short training field (time domain, x32768).
    localparam logic [31:0] STS_ROM [STS_LEN] = '{
        iq( 1507,  1507), iq(-4325,    66), iq( -426, -2589), iq( 4686,  -426),
        iq( 3015,     0), iq( 4686,  -426), iq( -426, -2589), iq(-4325,    66),
        iq( 1507,  1507), iq(   66, -4325), iq(-2589,  -426), iq( -426,  4686),
        iq(    0,  3015), iq( -426,  4686), iq(-2589,  -426), iq(   66, -4325)
    };

    // One 64-sample long training symbol (time domain, x32768).
    localparam logic [31:0] LTS_ROM [LTS_LEN] = '{
        iq(-5112,     0), iq(  393, -3211), iq( 3015, -3473), iq(-3015, -3768),
        iq(  -98, -1769), iq( 2458,  2425), iq(-4162,   688), iq(-3998,   557),
        iq(-1147,  4948), iq(-1835,   721), iq(-1966, -2654), iq( 2294,  -459),
        iq( 2687, -3015), iq(-4293, -2130), iq(-1868, -1278), iq( 1212, -3211),
        iq( 2032,  2032), iq( 3899,   131), iq( -721, -5276), iq( 1933,   492),
        iq(  786,  1933), iq(-4489,  1540), iq(   33,  3768), iq( 1737,  -131),
        iq( 3211,   852), iq(-1245,  3473), iq(-3768,  1802), iq( 1966,  2884),
        iq(  688,  -918), iq( 3178, -2720), iq( 1311,  3637), iq( -164,  3932),
        iq( 5112,     0), iq( -164, -3932), iq( 1311, -3637), iq( 3178,  2720),
        iq(  688,   918), iq( 1966, -2884), iq(-3768, -1802), iq(-1245, -3473),
        iq( 3211,  -852), iq( 1737,   131), iq(   33, -3768), iq(-4489, -1540),
        iq(  786, -1933), iq( 1933,  -492), iq( -721,  5276), iq( 3899,  -131),
        iq( 2032, -2032), iq( 1212,  3211), iq(-1868,  1278), iq(-4293,  2130),
        iq( 2687,  3015), iq( 2294,   459), iq(-1966,  2654), iq(-1835,  -721),
        iq(-1147, -4948), iq(-3998,  -557), iq(-4162,  -688), iq( 2458, -2425),
        iq(  -98,  1769), iq(-3015,  3768), iq( 3015,  3473), iq(  393,  3211)
    };

endpackage

// File: rtl/preamble_tx_if.sv
// AXI-Stream sample bus carrying {I,Q} preamble beats from the generator to the DAC path.
interface preamble_tx_if;

    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/preamble_rom.sv
// Combinational preamble lookup: STS table when i_sts_sel is high, otherwise the LTS table.
module preamble_rom
    import wifi_preamble_pkg::*;
(
    input  logic        i_sts_sel,
    input  logic [5:0]  i_addr,
    output logic [31:0] o_sample
);

    // Table select; the STS period is 16 deep so only the low address nibble applies.
    always_comb begin
        if (i_sts_sel) begin
            o_sample = STS_ROM[i_addr[3:0]];
        end else begin
            o_sample = LTS_ROM[i_addr];
        end
    end

endmodule

// File: rtl/preamble_tx.sv
// Legacy 802.11a/g training-field generator: STS x NUM_STS_REPS, GI2, LTS1, LTS2 as an
// AXI-Stream of {I,Q} beats. In continuous mode the frame repeats after GAP_SAMPLES zero beats.
// All stream outputs are registered; the ROM is addressed with the *next* beat's position.
module preamble_tx
    import wifi_preamble_pkg::*;
#(
    parameter int SCALE_SHIFT  = 0,
    parameter int NUM_STS_REPS = 10,
    parameter int GAP_SAMPLES  = 0
) (
    input  logic          clk_in,
    input  logic          aresetn,
    input  logic          start_in,
    input  logic          continuous_in,
    preamble_tx_if.master tx_axis,
    output logic          busy_out,
    output logic          done_out,
    output logic [8:0]    sample_idx_out
);

    tx_state_t          r_state;
    logic [15:0]        r_cnt;
    logic [8:0]         r_idx;
    logic               r_tvalid;
    logic               r_tlast;
    logic [31:0]        r_tdata;
    logic               r_busy;
    logic               r_done;

    tx_state_t          w_nxt_state;
    logic [15:0]        w_nxt_cnt;
    logic [8:0]         w_nxt_idx;
    logic               w_nxt_tlast;
    logic [31:0]        w_nxt_tdata;
    logic               w_last_beat;
    logic               w_advance;
    logic               w_frame_end;
    logic               w_rom_sts_sel;
    logic [5:0]         w_rom_addr;
    logic [31:0]        w_rom_sample;
    logic signed [15:0] w_i_shift;
    logic signed [15:0] w_q_shift;

    preamble_rom u_rom (
        .i_sts_sel (w_rom_sts_sel),
        .i_addr    (w_rom_addr),
        .o_sample  (w_rom_sample)
    );

    // Next-beat decode: which state/position follows the beat currently on the bus.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        w_last_beat = (r_cnt == state_last(r_state, NUM_STS_REPS, GAP_SAMPLES));
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 16'd1;
        w_frame_end = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_nxt_cnt = '0;
                if (start_in) begin
                    w_nxt_state = TX_STS;
                end
            end
            TX_STS: begin
                if (w_last_beat) begin
                    w_nxt_state = TX_GI;
                    w_nxt_cnt   = '0;
                end
            end
            TX_GI: begin
                if (w_last_beat) begin
                    w_nxt_state = TX_LTS1;
                    w_nxt_cnt   = '0;
                end
            end
            TX_LTS1: begin
                if (w_last_beat) begin
                    w_nxt_state = TX_LTS2;
                    w_nxt_cnt   = '0;
                end
            end
            TX_LTS2: begin
                if (w_last_beat) begin
                    w_frame_end = 1'b1;
                    w_nxt_cnt   = '0;
                    if (!continuous_in) begin
                        w_nxt_state = TX_IDLE;
                    end else if (GAP_SAMPLES > 0) begin
                        w_nxt_state = TX_GAP;
                    end else begin
                        w_nxt_state = TX_STS;
                    end
                end
            end
            TX_GAP: begin
                if (w_last_beat) begin
                    w_nxt_state = TX_STS;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = TX_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // ROM address for the next beat: STS wraps every 16, GI reads the LTS second half.
    always_comb begin
        w_rom_sts_sel = (w_nxt_state == TX_STS);
        case (w_nxt_state)
            TX_STS:  w_rom_addr = {2'b00, w_nxt_cnt[3:0]};
            TX_GI:   w_rom_addr = {1'b1, w_nxt_cnt[4:0]};
            default: w_rom_addr = w_nxt_cnt[5:0];
        endcase
    end

    // Backoff scaling, per-component arithmetic shift (sign-extending, truncating).
    always_comb begin
        w_i_shift = $signed(w_rom_sample[31:16]) >>> SCALE_SHIFT;
        w_q_shift = $signed(w_rom_sample[15:0]) >>> SCALE_SHIFT;
    end

    // Next registered output values; gap and idle beats carry zero data and index 0.
    always_comb begin
        w_advance = (r_state == TX_IDLE) ? start_in : (r_tvalid && tx_axis.tready);
        if (w_nxt_state inside {TX_STS, TX_GI, TX_LTS1, TX_LTS2}) begin
            w_nxt_tdata = {w_i_shift, w_q_shift};
        end else begin
            w_nxt_tdata = '0;
        end
        if ((r_state inside {TX_IDLE, TX_GAP}) || w_frame_end) begin
            w_nxt_idx = '0;
        end else begin
            w_nxt_idx = r_idx + 9'd1;
        end
        w_nxt_tlast = (w_nxt_state == TX_LTS2) && (w_nxt_cnt == 16'(LTS_LEN - 1));
    end

    // Sequencer and registered stream outputs; state moves only on start (idle) or a handshake.
    always_ff @(posedge clk_in) begin
        // NOTE: reset is sampled on the clock edge; a reset mid-frame drops the frame outright.
        if (!aresetn) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_done <= 1'b0;
            if (w_advance) begin
                r_state  <= w_nxt_state;
                r_cnt    <= w_nxt_cnt;
                r_idx    <= w_nxt_idx;
                r_tvalid <= (w_nxt_state != TX_IDLE);
                r_tlast  <= w_nxt_tlast;
                r_tdata  <= w_nxt_tdata;
                r_busy   <= (w_nxt_state != TX_IDLE);
                r_done   <= w_frame_end && (w_nxt_state == TX_IDLE);
            end
        end
    end

    assign tx_axis.tvalid = r_tvalid;
    assign tx_axis.tdata  = r_tdata;
    assign tx_axis.tlast  = r_tlast;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign sample_idx_out = r_idx;

endmodule

// File: tb/tb_preamble_tx.sv
// Self-checking bench for preamble_tx: two instances (default, and SCALE_SHIFT=2 / GAP_SAMPLES=8)
// with scoreboards filled at stimulus time and a negedge monitor capturing handshaken beats.
module tb_preamble_tx;
    import wifi_preamble_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [8:0]  idx;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       aresetn = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0, cont0 = 1'b0, cont1 = 1'b0;
    logic       busy0, busy1, done0, done1;
    logic [8:0] idx0, idx1;

    preamble_tx_if if0 ();
    preamble_tx_if if1 ();

    preamble_tx u_dut0 (
        .clk_in         (clk),
        .aresetn        (aresetn),
        .start_in       (start0),
        .continuous_in  (cont0),
        .tx_axis        (if0),
        .busy_out       (busy0),
        .done_out       (done0),
        .sample_idx_out (idx0)
    );

    preamble_tx #(.SCALE_SHIFT(2), .NUM_STS_REPS(10), .GAP_SAMPLES(8)) u_dut1 (
        .clk_in         (clk),
        .aresetn        (aresetn),
        .start_in       (start1),
        .continuous_in  (cont1),
        .tx_axis        (if1),
        .busy_out       (busy1),
        .done_out       (done1),
        .sample_idx_out (idx1)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t sb0[$], sb1[$], got0[$], got1[$];
    int    done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = 0, last_cyc0 = 0, first_cyc0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every beat that will transfer on the coming edge, plus done pulses.
    always @(negedge clk) begin
        if (if0.tvalid && if0.tready) begin
            if (got0.size() == 0) first_cyc0 = cyc;
            got0.push_back(beat_t'{data: if0.tdata, last: if0.tlast, idx: idx0});
            if (if0.tlast) last_cyc0 = cyc;
        end
        if (if1.tvalid && if1.tready) begin
            got1.push_back(beat_t'{data: if1.tdata, last: if1.tlast, idx: idx1});
        end
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (done1) done_cnt1++;
    end

    // Reference sample for frame beat b, independently derived from the frame layout.
    function automatic logic [31:0] exp_beat(input int b, input int sh);
        logic [31:0]        raw;
        logic signed [15:0] i_s, q_s;
        if (b < 160)      raw = STS_ROM[4'(b % 16)];
        else if (b < 192) raw = LTS_ROM[6'(b - 160 + 32)];
        else if (b < 256) raw = LTS_ROM[6'(b - 192)];
        else              raw = LTS_ROM[6'(b - 256)];
        i_s = raw[31:16];
        q_s = raw[15:0];
        i_s = i_s >>> sh;
        q_s = q_s >>> sh;
        return {i_s, q_s};
    endfunction

    task automatic push_frame(input int which, input int sh);
        for (int b = 0; b < FRAME_LEN; b++) begin
            beat_t e;
            e.data = exp_beat(b, sh);
            e.last = (b == FRAME_LEN - 1);
            e.idx  = 9'(b);
            if (which == 0) sb0.push_back(e);
            else            sb1.push_back(e);
        end
    endtask

    task automatic push_gap(input int n);
        for (int b = 0; b < n; b++) sb1.push_back(beat_t'{data: 32'h0, last: 1'b0, idx: 9'd0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear0();
        sb0.delete(); got0.delete(); done_cnt0 = 0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        start0  = 1'b1;                       // start coincident with reset must lose
        repeat (3) tick();
        n_checks += 7;
        if (if0.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", if0.tvalid); end
        if (if0.tlast !== 1'b0)  begin n_fail++; $display("FAIL reset_tlast: got %b want 0", if0.tlast); end
        if (if0.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", if0.tdata); end
        if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        if (done0 !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        if (idx0 !== 9'd0)       begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx0); end
        if (if1.tvalid !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut1: got tvalid=%b busy=%b want 0 0", if1.tvalid, busy1);
        end
        start0  = 1'b0;
        aresetn = 1'b1;
        tick();
        n_checks++;
        if (if0.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got tvalid=%b want 0", if0.tvalid); end
    endtask

    task automatic test_single_frame();
        clear0();
        if0.tready = 1'b1;
        push_frame(0, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_checks += 2;
        if (if0.tvalid !== 1'b1 || if0.tdata !== exp_beat(0, 0) || idx0 !== 9'd0) begin
            n_fail++; $display("FAIL latency_beat0: got v=%b d=%h i=%0d want 1 %h 0", if0.tvalid, if0.tdata, idx0, exp_beat(0, 0));
        end
        if (if0.tdata !== 32'h05E3_05E3) begin n_fail++; $display("FAIL sts0_const: got %h want 05e305e3", if0.tdata); end
        for (int c = 0; c < 1000 && done_cnt0 == 0; c++) tick();
        repeat (3) tick();
        n_checks += 4;
        if (done_cnt0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt0); end
        if (done_cyc0 !== last_cyc0 + 1) begin n_fail++; $display("FAIL done_timing: got cyc %0d want %0d", done_cyc0, last_cyc0 + 1); end
        if (if0.tvalid !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", if0.tvalid, busy0); end
        if (got0.size() !== sb0.size()) begin n_fail++; $display("FAIL single_len: got %0d want %0d", got0.size(), sb0.size()); end
        for (int k = 0; k < sb0.size() && k < got0.size(); k++) begin
            n_checks++;
            if (got0[k] !== sb0[k]) begin
                n_fail++; $display("FAIL single_beat[%0d]: got %h/%b/%0d want %h/%b/%0d", k, got0[k].data, got0[k].last, got0[k].idx, sb0[k].data, sb0[k].last, sb0[k].idx);
            end
        end
        if (got0.size() >= FRAME_LEN) begin
            int bad_sts = 0, bad_gi = 0, bad_lts = 0, bad_last = 0;
            for (int k = 0; k < 16; k++) if (got0[k].data !== got0[k + 16].data) bad_sts++;
            for (int k = 0; k < 32; k++) if (got0[160 + k].data !== got0[288 + k].data || got0[160 + k].data !== got0[224 + k].data) bad_gi++;
            for (int k = 0; k < 64; k++) if (got0[192 + k].data !== got0[256 + k].data) bad_lts++;
            for (int k = 0; k < FRAME_LEN; k++) if (got0[k].last !== (k == FRAME_LEN - 1)) bad_last++;
            n_checks += 5;
            if (bad_sts != 0)  begin n_fail++; $display("FAIL sts_period: got %0d differing beats want 0", bad_sts); end
            if (bad_gi != 0)   begin n_fail++; $display("FAIL gi_prefix: got %0d differing beats want 0", bad_gi); end
            if (bad_lts != 0)  begin n_fail++; $display("FAIL lts_repeat: got %0d differing beats want 0", bad_lts); end
            if (bad_last != 0) begin n_fail++; $display("FAIL tlast_place: got %0d wrong tlast beats want 0", bad_last); end
            if (got0[160].data !== 32'h13F8_0000) begin n_fail++; $display("FAIL gi0_const: got %h want 13f80000", got0[160].data); end
        end
    endtask

    task automatic test_backpressure();
        logic        prev_stall = 1'b0;
        logic [31:0] sd = '0;
        logic [8:0]  si = '0;
        logic        sl = 1'b0;
        int          stalls = 0;
        clear0();
        push_frame(0, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 3000 && done_cnt0 == 0; c++) begin
            if (prev_stall) begin
                stalls++;
                n_checks++;
                if (if0.tvalid !== 1'b1 || if0.tdata !== sd || idx0 !== si || if0.tlast !== sl) begin
                    n_fail++; $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b want 1 %h %0d %b", if0.tvalid, if0.tdata, idx0, if0.tlast, sd, si, sl);
                end
            end
            if0.tready = 1'($urandom_range(0, 1));
            prev_stall = if0.tvalid && !if0.tready;
            sd = if0.tdata; si = idx0; sl = if0.tlast;
            tick();
        end
        if0.tready = 1'b1;
        repeat (2) tick();
        n_checks += 3;
        if (stalls == 0) begin n_fail++; $display("FAIL bp_stalls_seen: got 0 want >0"); end
        if (done_cnt0 !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt0); end
        if (got0.size() !== sb0.size()) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", got0.size(), sb0.size()); end
        for (int k = 0; k < sb0.size() && k < got0.size(); k++) begin
            n_checks++;
            if (got0[k] !== sb0[k]) begin
                n_fail++; $display("FAIL bp_beat[%0d]: got %h/%b/%0d want %h/%b/%0d", k, got0[k].data, got0[k].last, got0[k].idx, sb0[k].data, sb0[k].last, sb0[k].idx);
            end
        end
    endtask

    task automatic test_start_ignored();
        clear0();
        if0.tready = 1'b1;
        start0 = 1'b1;
        tick();
        for (int c = 0; c < 1000 && done_cnt0 == 0; c++) begin
            start0 = (idx0 == 9'd50);
            tick();
        end
        start0 = 1'b0;
        repeat (30) tick();
        n_checks += 3;
        if (got0.size() !== FRAME_LEN) begin n_fail++; $display("FAIL restart_len: got %0d want %0d", got0.size(), FRAME_LEN); end
        if (done_cnt0 !== 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", done_cnt0); end
        if (if0.tvalid !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got v=%b busy=%b want 0 0", if0.tvalid, busy0); end
    endtask

    task automatic test_back_to_back();
        clear0();
        if0.tready = 1'b1;
        cont0 = 1'b1;
        push_frame(0, 0);
        push_frame(0, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 2000 && done_cnt0 == 0; c++) begin
            if (got0.size() >= 400) cont0 = 1'b0;
            tick();
        end
        cont0 = 1'b0;
        repeat (2) tick();
        n_checks += 3;
        if (done_cnt0 !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d want 1", done_cnt0); end
        if (last_cyc0 - first_cyc0 !== 2 * FRAME_LEN - 1) begin
            n_fail++; $display("FAIL b2b_no_idle: got span %0d want %0d", last_cyc0 - first_cyc0, 2 * FRAME_LEN - 1);
        end
        if (got0.size() !== sb0.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", got0.size(), sb0.size()); end
        for (int k = 0; k < sb0.size() && k < got0.size(); k++) begin
            n_checks++;
            if (got0[k] !== sb0[k]) begin
                n_fail++; $display("FAIL b2b_beat[%0d]: got %h/%b/%0d want %h/%b/%0d", k, got0[k].data, got0[k].last, got0[k].idx, sb0[k].data, sb0[k].last, sb0[k].idx);
            end
        end
    endtask

    task automatic test_continuous_gap();
        int bad_rep = 0;
        sb1.delete(); got1.delete(); done_cnt1 = 0;
        cont1 = 1'b1;
        push_frame(1, 2);
        push_gap(8);
        push_frame(1, 2);
        start1 = 1'b1;
        if1.tready = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 4000 && done_cnt1 == 0; c++) begin
            if (got1.size() >= 400) cont1 = 1'b0;
            if1.tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        if1.tready = 1'b1;
        cont1 = 1'b0;
        repeat (2) tick();
        n_checks += 3;
        if (done_cnt1 !== 1) begin n_fail++; $display("FAIL gap_done: got %0d want 1", done_cnt1); end
        if (if1.tvalid !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL gap_idle: got v=%b busy=%b want 0 0", if1.tvalid, busy1); end
        if (got1.size() !== sb1.size()) begin n_fail++; $display("FAIL gap_len: got %0d want %0d", got1.size(), sb1.size()); end
        for (int k = 0; k < sb1.size() && k < got1.size(); k++) begin
            n_checks++;
            if (got1[k] !== sb1[k]) begin
                n_fail++; $display("FAIL gap_beat[%0d]: got %h/%b/%0d want %h/%b/%0d", k, got1[k].data, got1[k].last, got1[k].idx, sb1[k].data, sb1[k].last, sb1[k].idx);
            end
        end
        if (got1.size() >= 2 * FRAME_LEN + 8) begin
            for (int k = 0; k < FRAME_LEN; k++) if (got1[k] !== got1[k + FRAME_LEN + 8]) bad_rep++;
            n_checks += 3;
            if (bad_rep != 0) begin n_fail++; $display("FAIL gap_repeat: got %0d differing beats want 0", bad_rep); end
            if (got1[0].data[31:16] !== 16'd376) begin n_fail++; $display("FAIL shift_pos: got %h want 0178", got1[0].data[31:16]); end
            if (got1[1].data[31:16] !== 16'hFBC6) begin n_fail++; $display("FAIL shift_neg: got %h want fbc6", got1[1].data[31:16]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear0();
        if0.tready = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 500 && idx0 != 9'd100; c++) tick();
        n_checks++;
        if (idx0 !== 9'd100) begin n_fail++; $display("FAIL midrst_reach: got idx %0d want 100", idx0); end
        aresetn = 1'b0;
        tick();
        n_checks++;
        if ({if0.tvalid, if0.tlast, if0.tdata, busy0, done0, idx0} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got v=%b l=%b d=%h b=%b dn=%b i=%0d want all 0", if0.tvalid, if0.tlast, if0.tdata, busy0, done0, idx0);
        end
        aresetn = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (if0.tvalid !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resume: got v=%b busy=%b want 0 0", if0.tvalid, busy0); end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_checks++;
        if (if0.tvalid !== 1'b1 || if0.tdata !== exp_beat(0, 0) || idx0 !== 9'd0) begin
            n_fail++; $display("FAIL midrst_restart: got v=%b d=%h i=%0d want 1 %h 0", if0.tvalid, if0.tdata, idx0, exp_beat(0, 0));
        end
        for (int c = 0; c < 1000 && done_cnt0 == 0; c++) tick();
        n_checks++;
        if (done_cnt0 !== 1) begin n_fail++; $display("FAIL midrst_done: got %0d want 1", done_cnt0); end
    endtask

    initial begin
        if0.tready = 1'b0;
        if1.tready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_continuous_gap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
